register_bank_dbuf: RTL and testbench

Double-buffered, parametrised register bank: the multi-entry successor to the single tick-gated latch register. Writes land in a shadow bank. An atomic commit copies the whole shadow bank into the active bank, which drives two combinational read ports. A sequenced clear sweep is also provided. The block sits between game-logic writers (board rows, score fields) and display/readout logic, so readers never see a half-updated frame.

---
 rtl/register_bank_dbuf_pkg.sv | 13 +
 rtl/register_bank_dbuf_row.sv | 36 +++
 rtl/register_bank_dbuf.sv | 131 +++++++++++++
 tb/tb_register_bank_dbuf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_dbuf_pkg.sv
// Shared types and helpers for the double-buffered register bank.
package register_bank_dbuf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int unsigned nr_of_regs(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/register_bank_dbuf_row.sv
// One masked-write register with synchronous reset, clear and load.
module register_bank_row #(
  parameter int unsigned          NrOfBits   = 8,
  parameter logic [NrOfBits-1:0]  ResetValue = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [NrOfBits-1:0] d,
  input  logic [NrOfBits-1:0] mask,
  output logic [NrOfBits-1:0] q
);

  logic [NrOfBits-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clear) begin
      val_d = ResetValue;
    end else if (load) begin
      val_d = (val_q & ~mask) | (d & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= ResetValue;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/register_bank_dbuf.sv
// Double-buffered register bank: masked writes to a shadow bank, atomic commit
// into the active bank that feeds two combinational read ports, plus clear sweep.
module register_bank_dbuf
  import register_bank_dbuf_pkg::*;
#(
  parameter int unsigned         NrOfBits   = 8,
  parameter int unsigned         AddrBits   = 3,
  parameter logic [NrOfBits-1:0] ResetValue = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] WrData,
  input  logic [NrOfBits-1:0] WrMask,
  input  logic                CommitReq,
  input  logic                ClearReq,
  output logic                CommitAck,
  output logic                Busy,
  input  logic [AddrBits-1:0] RdAddrA,
  input  logic [AddrBits-1:0] RdAddrB,
  output logic [NrOfBits-1:0] RdDataA,
  output logic [NrOfBits-1:0] RdDataB
);

  localparam int unsigned         NrOfRegs = nr_of_regs(AddrBits);
  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NrOfRegs - 1);

  state_e              state_q, state_d;
  logic [AddrBits-1:0] ptr_q, ptr_d;
  logic                ack_q, ack_d;
  logic                advance;
  logic                wr_go, commit_go, sweep_go;

  logic [NrOfBits-1:0] shadow_q    [NrOfRegs];
  logic [NrOfBits-1:0] active_q    [NrOfRegs];
  logic [NrOfBits-1:0] commit_data [NrOfRegs];

  assign advance = ClockEnable & Tick;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ack_d     = 1'b0;
    wr_go     = 1'b0;
    commit_go = 1'b0;
    sweep_go  = 1'b0;
    if (advance) begin
      unique case (state_q)
        ST_IDLE: begin
          wr_go = WrEn;
          // Clear wins over commit; the commit request simply stays pending.
          if (ClearReq) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
          end else if (CommitReq) begin
            commit_go = 1'b1;
            ack_d     = 1'b1;
          end
        end
        ST_CLEAR: begin
          sweep_go = 1'b1;
          ptr_d    = ptr_q + 1'b1;
          if (ptr_q == LastAddr) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

  // Commit copies shadow as it will be after this edge, so a same-cycle write lands too.
  always_comb begin
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      commit_data[i] = shadow_q[i];
      if (wr_go && (WrAddr == AddrBits'(i))) begin
        commit_data[i] = (shadow_q[i] & ~WrMask) | (WrData & WrMask);
      end
    end
  end

  for (genvar g = 0; g < NrOfRegs; g++) begin : g_regs
    register_bank_row #(
      .NrOfBits   (NrOfBits),
      .ResetValue (ResetValue)
    ) u_shadow (
      .clk   (Clock),
      .rst   (Reset),
      .clear (sweep_go && (ptr_q == AddrBits'(g))),
      .load  (wr_go && (WrAddr == AddrBits'(g))),
      .d     (WrData),
      .mask  (WrMask),
      .q     (shadow_q[g])
    );

    register_bank_row #(
      .NrOfBits   (NrOfBits),
      .ResetValue (ResetValue)
    ) u_active (
      .clk   (Clock),
      .rst   (Reset),
      .clear (1'b0),
      .load  (commit_go),
      .d     (commit_data[g]),
      .mask  ('1),
      .q     (active_q[g])
    );
  end

  assign CommitAck = ack_q;
  assign Busy      = (state_q == ST_CLEAR);
  assign RdDataA   = active_q[RdAddrA];
  assign RdDataB   = active_q[RdAddrB];

endmodule

// File: tb/tb_register_bank_dbuf.sv
// Randomised + directed bench for register_bank_dbuf against a behavioural bank model.
module tb_register_bank_dbuf;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       Reset, ClockEnable, Tick, WrEn, CommitReq, ClearReq;
  logic [2:0] WrAddr, RdAddrA, RdAddrB;
  logic [7:0] WrData, WrMask, RdDataA, RdDataB;
  logic       CommitAck, Busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_sh  [8];
  logic [7:0] m_act [8];
  int         m_left;
  int         m_idx;
  logic       m_ack;
  bit         m_valid = 0;

  register_bank_dbuf #(
    .NrOfBits   (8),
    .AddrBits   (3),
    .ResetValue (RV)
  ) dut (
    .Clock       (clk),
    .Reset       (Reset),
    .ClockEnable (ClockEnable),
    .Tick        (Tick),
    .WrEn        (WrEn),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .WrMask      (WrMask),
    .CommitReq   (CommitReq),
    .ClearReq    (ClearReq),
    .CommitAck   (CommitAck),
    .Busy        (Busy),
    .RdAddrA     (RdAddrA),
    .RdAddrB     (RdAddrB),
    .RdDataA     (RdDataA),
    .RdDataB     (RdDataB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank behaviour expressed as: shadow/active arrays and a count of sweep steps left.
  task automatic model_edge();
    logic ack_n;
    ack_n = 1'b0;
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        m_sh[i]  = RV;
        m_act[i] = RV;
      end
      m_left  = 0;
      m_idx   = 0;
      m_valid = 1;
    end else if (ClockEnable && Tick) begin
      if (m_left == 0) begin
        if (WrEn) m_sh[WrAddr] = (m_sh[WrAddr] & ~WrMask) | (WrData & WrMask);
        if (ClearReq) begin
          m_left = 8;
          m_idx  = 0;
        end else if (CommitReq) begin
          for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
          ack_n = 1'b1;
        end
      end else begin
        m_sh[m_idx] = RV;
        m_idx++;
        m_left--;
      end
    end
    m_ack = Reset ? 1'b0 : ack_n;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model with the edge's inputs.
  task automatic cycle();
    @(negedge clk);
    if (m_valid) begin
      lit("busy", 32'(Busy), 32'(m_left != 0));
      lit("ack", 32'(CommitAck), 32'(m_ack));
      lit("rd_a", 32'(RdDataA), 32'(m_act[RdAddrA]));
      lit("rd_b", 32'(RdDataB), 32'(m_act[RdAddrB]));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 0; ClockEnable = 0; Tick = 0; WrEn = 0; CommitReq = 0; ClearReq = 0;
    WrAddr = 0; WrData = 0; WrMask = 0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] m,
                       input logic commit);
    ClockEnable = 1; Tick = 1; WrEn = 1; WrAddr = a; WrData = d; WrMask = m;
    CommitReq = commit;
    cycle();
    idle_inputs();
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      RdAddrA = 3'(i);
      RdAddrB = 3'(7 - i);
      cycle();
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    RdAddrA = 3; RdAddrB = 0;
    Reset = 1;
    cycle();
    cycle();
    idle_inputs();
    lit("reset_busy", 32'(Busy), 0);
    lit("reset_ack", 32'(CommitAck), 0);
    lit("reset_rd_a", 32'(RdDataA), 32'hA5);
    lit("reset_rd_b", 32'(RdDataB), 32'hA5);
    read_all();

    // Shadow write invisible until commit; commit pulses ack for one clock.
    RdAddrA = 3; RdAddrB = 3;
    write(3, 8'h3C, 8'hFF, 0);
    lit("no_commit_rd", 32'(RdDataA), 32'hA5);
    ClockEnable = 1; Tick = 1; CommitReq = 1;
    cycle();
    idle_inputs();
    lit("commit_rd", 32'(RdDataA), 32'h3C);
    lit("commit_ack_hi", 32'(CommitAck), 1);
    cycle();
    lit("commit_ack_lo", 32'(CommitAck), 0);

    // Masked write over 00, committed in the same advance cycle.
    RdAddrA = 2; RdAddrB = 5;
    write(2, 8'h00, 8'hFF, 0);
    write(2, 8'hFF, 8'h0F, 1);
    lit("masked_same_cycle", 32'(RdDataA), 32'h0F);
    write(5, 8'h77, 8'hFF, 1);
    lit("same_cycle_commit", 32'(RdDataB), 32'h77);

    // Tick low freezes everything; one tick pulse acts on that edge only.
    RdAddrA = 1;
    ClockEnable = 1; Tick = 0; WrEn = 1; WrAddr = 1; WrData = 8'h11; WrMask = 8'hFF;
    CommitReq = 1;
    repeat (5) cycle();
    lit("tick_low_rd", 32'(RdDataA), 32'hA5);
    lit("tick_low_ack", 32'(CommitAck), 0);
    Tick = 1;
    cycle();
    idle_inputs();
    lit("tick_pulse_rd", 32'(RdDataA), 32'h11);
    lit("tick_pulse_ack", 32'(CommitAck), 1);

    // Clear sweep: 8 advance cycles, write dropped, held commit fires afterwards.
    RdAddrA = 3; RdAddrB = 4;
    ClockEnable = 1; Tick = 1; ClearReq = 1;
    cycle();
    lit("clear_busy_rise", 32'(Busy), 1);
    ClearReq = 0; CommitReq = 1;
    WrEn = 1; WrAddr = 4; WrData = 8'h99; WrMask = 8'hFF;
    n = 0;
    do begin
      cycle();
      WrEn = 0;
      n++;
    end while (Busy && n < 20);
    lit("clear_len", 32'(n), 8);
    lit("clear_active_kept", 32'(RdDataA), 32'h3C);
    cycle();
    idle_inputs();
    lit("post_clear_ack", 32'(CommitAck), 1);
    lit("post_clear_rd3", 32'(RdDataA), 32'hA5);
    lit("post_clear_rd4", 32'(RdDataB), 32'hA5);
    read_all();

    // Reset in the middle of a sweep with ClockEnable low.
    RdAddrA = 6;
    write(6, 8'h5A, 8'hFF, 1);
    lit("pre_reset_rd", 32'(RdDataA), 32'h5A);
    ClockEnable = 1; Tick = 1; ClearReq = 1;
    cycle();
    ClearReq = 0;
    repeat (3) cycle();
    lit("mid_sweep_busy", 32'(Busy), 1);
    ClockEnable = 0; Reset = 1; CommitReq = 1;
    cycle();
    lit("reset_sweep_busy", 32'(Busy), 0);
    lit("reset_sweep_rd", 32'(RdDataA), 32'hA5);
    idle_inputs();
    read_all();

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      Reset       = ($urandom_range(0, 299) == 0);
      ClockEnable = ($urandom_range(0, 3) != 0);
      Tick        = ($urandom_range(0, 3) != 0);
      WrEn        = ($urandom_range(0, 1) == 0);
      WrAddr      = 3'($urandom);
      WrData      = 8'($urandom);
      WrMask      = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      CommitReq   = ($urandom_range(0, 3) == 0);
      ClearReq    = ($urandom_range(0, 39) == 0);
      RdAddrA     = 3'($urandom);
      RdAddrB     = ($urandom_range(0, 4) == 0) ? RdAddrA : 3'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
